// File: rtl/cmp_pkg.sv
// cmp_pkg: mode and FSM state encodings shared by serial_comparator and its digit slice.
package cmp_pkg;
   localparam logic [1:0] CMP_MODE_EQ  = 2'd0;
   localparam logic [1:0] CMP_MODE_XGT = 2'd1;
   localparam logic [1:0] CMP_MODE_YGT = 2'd2;
   localparam logic [1:0] CMP_MODE_MAX = 2'd3;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/cmp_digit_slice.sv
// cmp_digit_slice: combinational DIGIT-bit ripple stage, LSB first.
// SERIAL_COMPARATOR_SIGNED_EN inverts the sign-bit rule on the last digit.
module cmp_digit_slice
   import cmp_pkg::*;
#(
   parameter int DIGIT = 2
) (
   input  logic             xg_in,
   input  logic             yg_in,
   input  logic [DIGIT-1:0] x_digit,
   input  logic [DIGIT-1:0] y_digit,
   input  logic             last,
   output logic             xg_out,
   output logic             yg_out
);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif
   always_comb begin
      xg_out = xg_in;
      yg_out = yg_in;
      for (int i = 0; i < DIGIT; i++) begin
         if (x_digit[i] ^ y_digit[i]) begin
            // a set sign bit marks the smaller two's complement operand
            xg_out = (SIGNED_EN && last && i == DIGIT - 1) ? y_digit[i] : x_digit[i];
            yg_out = (SIGNED_EN && last && i == DIGIT - 1) ? x_digit[i] : y_digit[i];
         end
      end
   end
endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: multi-cycle magnitude comparator, DIGIT bits per clock, LSB digit first.
// Define SERIAL_COMPARATOR_SIGNED_EN for two's complement operands.
module serial_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] o,
   output logic             x_gt,
   output logic             y_gt
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   state_t state;
   logic [WIDTH-1:0] xs, ys, xn, yn, res;
   logic [1:0] mode_r;
   logic [CW-1:0] cnt;
   logic xg, yg, xg_n, yg_n, last;
   assign last = cnt == LAST;
   // operands rotate one digit per run cycle and are back in place after N cycles
   assign xn = (xs >> DIGIT) | (xs << (WIDTH - DIGIT));
   assign yn = (ys >> DIGIT) | (ys << (WIDTH - DIGIT));
   assign res = mode_r == CMP_MODE_MAX ? (xg_n ? xn : yn) :
                {{(WIDTH-1){1'b0}}, mode_r == CMP_MODE_EQ  ? ~(xg_n | yg_n) :
                                    mode_r == CMP_MODE_XGT ? xg_n : yg_n};
   cmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .xg_in  (xg),
      .yg_in  (yg),
      .x_digit(xs[DIGIT-1:0]),
      .y_digit(ys[DIGIT-1:0]),
      .last   (last),
      .xg_out (xg_n),
      .yg_out (yg_n)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         o      <= '0;
         x_gt   <= 1'b0;
         y_gt   <= 1'b0;
         xs     <= '0;
         ys     <= '0;
         mode_r <= '0;
         cnt    <= '0;
         xg     <= 1'b0;
         yg     <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               xs  <= xn;
               ys  <= yn;
               xg  <= xg_n;
               yg  <= yg_n;
               cnt <= cnt + 1'b1;
               if (last) begin
                  x_gt  <= xg_n;
                  y_gt  <= yg_n;
                  o     <= res;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  xs     <= x;
                  ys     <= y;
                  mode_r <= mode;
                  xg     <= 1'b0;
                  yg     <= 1'b0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: vector table, hand sequences and randomized runs against an arithmetic model.
// Honors SERIAL_COMPARATOR_SIGNED_EN for the expected values.
module tb_serial_comparator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [1:0] mode = '0;
   logic [7:0] x = '0, y = '0;
   logic busy, done, x_gt, y_gt;
   logic [7:0] o;
   logic start16 = 1'b0;
   logic [1:0] mode16 = '0;
   logic [15:0] x16 = '0, y16 = '0;
   logic busy16, done16, xgt16, ygt16;
   logic [15:0] o16;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_comparator #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .x(x), .y(y),
      .busy(busy), .done(done), .o(o), .x_gt(x_gt), .y_gt(y_gt)
   );

   serial_comparator #(.WIDTH(16), .DIGIT(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16), .x(x16), .y(y16),
      .busy(busy16), .done(done16), .o(o16), .x_gt(xgt16), .y_gt(ygt16)
   );

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [1:0] mode;
      logic [7:0] o;
      logic       xgt;
      logic       ygt;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_o(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] m, output logic xg, output logic yg);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      xg = $signed(a) > $signed(b);
      yg = $signed(b) > $signed(a);
`else
      xg = a > b;
      yg = b > a;
`endif
      case (m)
         2'd0: ref_o = {7'd0, a == b};
         2'd1: ref_o = {7'd0, xg};
         2'd2: ref_o = {7'd0, yg};
         default: ref_o = xg ? a : b;
      endcase
   endfunction

   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                         input bit scramble, output int lat, output int bcnt);
      @(negedge clk);
      x = a; y = b; mode = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
         x = 8'($urandom); y = 8'($urandom); mode = 2'($urandom);
      end
      lat = 1;
      bcnt = int'(busy);
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         bcnt += int'(busy);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[9];
      int lat, bcnt, lat2, nd;
      logic exg, eyg;
      logic [7:0] eo, eo2;
      tbl[0] = '{8'h35, 8'h35, 2'd0, 8'h01, 1'b0, 1'b0};
      tbl[5] = '{8'h12, 8'h34, 2'd2, 8'h01, 1'b0, 1'b1};
      tbl[6] = '{8'h12, 8'h34, 2'd0, 8'h00, 1'b0, 1'b1};
      tbl[7] = '{8'hFF, 8'hFF, 2'd3, 8'hFF, 1'b0, 1'b0};
      tbl[8] = '{8'h00, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0};
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      tbl[1] = '{8'hA0, 8'h0F, 2'd1, 8'h00, 1'b0, 1'b1};
      tbl[2] = '{8'hA0, 8'h0F, 2'd3, 8'h0F, 1'b0, 1'b1};
      tbl[3] = '{8'hA0, 8'h0F, 2'd2, 8'h01, 1'b0, 1'b1};
      tbl[4] = '{8'h80, 8'h01, 2'd3, 8'h01, 1'b0, 1'b1};
`else
      tbl[1] = '{8'hA0, 8'h0F, 2'd1, 8'h01, 1'b1, 1'b0};
      tbl[2] = '{8'hA0, 8'h0F, 2'd3, 8'hA0, 1'b1, 1'b0};
      tbl[3] = '{8'hA0, 8'h0F, 2'd2, 8'h00, 1'b1, 1'b0};
      tbl[4] = '{8'h80, 8'h01, 2'd3, 8'h80, 1'b1, 1'b0};
`endif
      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_o", o, 0);
      check("rst_xgt", x_gt, 0);
      check("rst_ygt", y_gt, 0);
      rst_n = 1'b1;
      // vector table
      for (int i = 0; i < 9; i++) begin
         launch(tbl[i].x, tbl[i].y, tbl[i].mode, 1'b1, lat, bcnt);
         check($sformatf("tbl%0d_latency", i), lat, 5);
         check($sformatf("tbl%0d_busy_cycles", i), bcnt, 4);
         check($sformatf("tbl%0d_o", i), o, tbl[i].o);
         check($sformatf("tbl%0d_xgt", i), x_gt, tbl[i].xgt);
         check($sformatf("tbl%0d_ygt", i), y_gt, tbl[i].ygt);
         @(negedge clk);
         check($sformatf("tbl%0d_done_pulse", i), done, 0);
      end
      // start during RUN is ignored
      eo = ref_o(8'hA0, 8'h0F, 2'd1, exg, eyg);
      @(negedge clk);
      x = 8'hA0; y = 8'h0F; mode = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      x = 8'h0F; y = 8'hA0; mode = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("ign_latency", lat, 5);
      check("ign_o", o, eo);
      check("ign_xgt", x_gt, exg);
      check("ign_ygt", y_gt, eyg);
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         nd += int'(done);
      end
      check("ign_no_extra_done", nd, 0);
      // back-to-back: start held through the DONE cycle
      eo = ref_o(8'hA0, 8'h0F, 2'd1, exg, eyg);
      @(negedge clk);
      x = 8'hA0; y = 8'h0F; mode = 2'd1; start = 1'b1;
      @(negedge clk);
      x = 8'h12; y = 8'h34; mode = 2'd2;
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_first_latency", lat, 5);
      check("b2b_first_o", o, eo);
      check("b2b_first_xgt", x_gt, exg);
      eo2 = ref_o(8'h12, 8'h34, 2'd2, exg, eyg);
      @(negedge clk);
      start = 1'b0;
      check("b2b_no_idle_busy", busy, 1);
      check("b2b_done_drop", done, 0);
      lat2 = 1;
      while (!done && lat2 < 20) begin
         @(negedge clk);
         lat2++;
      end
      check("b2b_second_gap", lat2, 5);
      check("b2b_second_o", o, eo2);
      check("b2b_second_ygt", y_gt, eyg);
      // asynchronous reset with the counter at 2
      @(negedge clk);
      x = 8'hA0; y = 8'h0F; mode = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_o", o, 0);
      check("midrst_xgt", x_gt, 0);
      check("midrst_ygt", y_gt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         nd += int'(done) + int'(busy);
      end
      check("midrst_quiet", nd, 0);
      // single-digit build
      @(negedge clk);
      x16 = 16'h0001; y16 = 16'h8000; mode16 = 2'd2; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (!done16 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("w16_latency", lat, 2);
`ifdef SERIAL_COMPARATOR_SIGNED_EN
      check("w16_o", o16, 16'h0000);
      check("w16_xgt", xgt16, 1);
`else
      check("w16_o", o16, 16'h0001);
      check("w16_ygt", ygt16, 1);
`endif
      // randomized runs, operands scrambled after start
      for (int i = 0; i < 150; i++) begin
         logic [7:0] a, b;
         logic [1:0] m;
         a = 8'($urandom);
         b = (i % 5 == 0) ? a : 8'($urandom);
         m = 2'($urandom_range(0, 3));
         eo = ref_o(a, b, m, exg, eyg);
         launch(a, b, m, 1'b1, lat, bcnt);
         check($sformatf("rnd%0d_latency", i), lat, 5);
         check($sformatf("rnd%0d_o a=%0h b=%0h m=%0d", i, a, b, m), o, eo);
         check($sformatf("rnd%0d_xgt", i), x_gt, exg);
         check($sformatf("rnd%0d_ygt", i), y_gt, eyg);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
